// File: rtl/multiplier_seq.sv
// -----------------------------------------------------------------------------
// multiplier_seq
//   Sequential shift-and-add unsigned multiplier with a start/busy/done
//   handshake. It is used to rebuild dividends from quotient and divisor in
//   arithmetic self-checks, and as a small multiplier in the datapath.
//
//   Timing, from the clock edge that samples start:
//   - WIDTH+1 cycles in RUN.
//   - One DONE cycle.
//   - Start to done is a fixed WIDTH+2 cycles.
//   - Consecutive operations repeat every WIDTH+3 cycles.
//
// Parameters
//   WIDTH         operand width in bits (2..16); product is 2*WIDTH bits
//
// Ports
//   clk           single clock, all state changes on its rising edge
//   rst_n         synchronous active-low reset, priority over all inputs
//   start         request, only honoured while idle
//   multiplicand  operand A, captured on an accepted start
//   multiplier    operand B, captured on an accepted start
//   busy          high while an operation is in RUN or DONE
//   done          one-cycle pulse; product is valid in that cycle
//   product       result register, held until the next completion or reset
// -----------------------------------------------------------------------------
module multiplier_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  // The counter reaches WIDTH after the last shift-and-add iteration.
  // The RUN cycle with that count commits the accumulator to product,
  // which gives the fixed WIDTH+1 cycle RUN phase.
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg,   state_next;
  logic [PW-1:0]    a_reg,       a_next;
  logic [PW-1:0]    acc_reg,     acc_next;
  logic [PW-1:0]    product_reg, product_next;
  logic [WIDTH-1:0] b_reg,       b_next;
  logic [CW-1:0]    cnt_reg,     cnt_next;
  logic [PW-1:0]    addend;

  // Partial product for this iteration.
  // The shifted multiplicand is gated by the current multiplier LSB.
  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_addend
      assign addend[gi] = a_reg[gi] & b_reg[0];
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    product_next = product_reg;
    busy         = 1'b0;
    done         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          a_next     = {{WIDTH{1'b0}}, multiplicand};
          b_next     = multiplier;
          acc_next   = '0;
          cnt_next   = '0;
        end
      end

      RUN: begin
        busy = 1'b1;
        if (cnt_reg == LAST_CNT) begin
          // All WIDTH iterations are folded into acc_reg.
          // Publish the result and move to DONE.
          state_next   = DONE;
          product_next = acc_reg;
        end else begin
          // 2*WIDTH-bit sum; the product of two WIDTH-bit values cannot overflow it.
          acc_next = acc_reg + addend;
          a_next   = a_reg << 1;
          b_next   = b_reg >> 1;
          cnt_next = cnt_reg + CW'(1);
        end
      end

      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      product_reg <= product_next;
    end
  end

  assign product = product_reg;

endmodule
